// File: rtl/halt_ctrl_pkg.sv
// Shared types and constants for the halt/console MMIO controller.
// Holds the FSM encoding, the register offset map and the watchdog exit code.
package halt_ctrl_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CON_W   = 8;
    localparam int unsigned CYCLE_W = 32;
    localparam int unsigned OFF_W   = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [OFF_W-1:0] OFF_CONSOLE  = 3'd0;
    localparam logic [OFF_W-1:0] OFF_EXIT     = 3'd1;
    localparam logic [OFF_W-1:0] OFF_CYCLE_LO = 3'd2;
    localparam logic [OFF_W-1:0] OFF_CYCLE_HI = 3'd3;
    localparam logic [OFF_W-1:0] OFF_STATUS   = 3'd4;

    localparam logic [DATA_W-1:0] WATCHDOG_RET = 16'hFFFF;

    // STATUS layout, full flag in bit 0.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic overflow,
        input logic draining,
        input logic empty,
        input logic full
    );
        return {12'b0, overflow, draining, empty, full};
    endfunction

endpackage

// File: rtl/halt_fifo.sv
// Synchronous FIFO with occupancy counter; push and pop may coincide even when full.
// Head entry is presented on rdata while not empty.
module halt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/halt_ctrl.sv
// MMIO halt controller: console byte FIFO, exit register, cycle counter with watchdog.
// The program halts once the console has drained after an EXIT store or watchdog expiry.
module halt_ctrl
    import halt_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [31:0] CYCLE_LIMIT = 32'd500000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        is_halt,
    output logic [15:0] ret_val
);

    state_e              state;
    logic [CYCLE_W-1:0]  cycle;
    logic [DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]   ret_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   ret_val_q;
    logic                halt_q;
    logic                overflow;

    logic                in_window;
    logic [OFF_W-1:0]    offset;
    logic                wr_hit;
    logic                con_wr;
    logic                exit_wr;
    logic                watchdog;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CON_W-1:0]    fifo_rdata;
    logic [DATA_W-1:0]   status;
    logic [DATA_W-1:0]   rd_val;

    // Window compare in 17 bits so a base near the top of the map cannot wrap.
    assign in_window = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, mem_addr} <= ({1'b0, BASE_ADDR} + 17'd7));
    assign offset    = OFF_W'(mem_addr - BASE_ADDR);
    assign wr_hit    = mem_we && in_window;
    assign con_wr    = wr_hit && (offset == OFF_CONSOLE) && (state == ST_RUN);
    assign exit_wr   = wr_hit && (offset == OFF_EXIT) && (state == ST_RUN);
    assign watchdog  = (state == ST_RUN) && (cycle == (CYCLE_LIMIT - 32'd1));

    assign fifo_push = con_wr;
    assign fifo_pop  = !fifo_empty && con_ready;
    assign status    = pack_status(overflow, state == ST_DRAIN, fifo_empty, fifo_full);

    halt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CON_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (mem_wdata[CON_W-1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read mux; anything outside the decoded registers reads as zero.
    always_comb begin
        rd_val = '0;
        if (in_window) begin
            case (offset)
                OFF_CYCLE_LO: rd_val = cycle[15:0];
                OFF_CYCLE_HI: rd_val = shadow;
                OFF_STATUS:   rd_val = status;
                default:      rd_val = '0;
            endcase
        end
    end

    // Run/drain/halt sequencing with registered halt outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ret_q     <= '0;
            halt_q    <= 1'b0;
            ret_val_q <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exit_wr) begin
                        state <= ST_DRAIN;
                        ret_q <= mem_wdata;
                    end else if (watchdog) begin
                        state <= ST_DRAIN;
                        ret_q <= WATCHDOG_RET;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state     <= ST_HALTED;
                        halt_q    <= 1'b1;
                        ret_val_q <= ret_q;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating cycle counter, frozen once halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle <= '0;
        end else if ((state != ST_HALTED) && (cycle != '1)) begin
            cycle <= cycle + CYCLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (con_wr && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Load path; a CYCLE_LO read snapshots the upper half for a coherent 32-bit read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            shadow  <= '0;
        end else if (mem_re) begin
            rdata_q <= rd_val;
            if (in_window && (offset == OFF_CYCLE_LO)) begin
                shadow <= cycle[31:16];
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign is_halt   = halt_q;
    assign ret_val   = ret_val_q;
    assign con_valid = !fifo_empty;
    assign con_data  = fifo_rdata;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: per-cycle vector tables plus hand sequences
// for watchdog timing, exit/watchdog collision and reset during drain.
module tb_halt_ctrl;

    localparam int unsigned LIMIT = 100;
    localparam logic [15:0] A_CON  = 16'hFF00;
    localparam logic [15:0] A_EXIT = 16'hFF01;
    localparam logic [15:0] A_CLO  = 16'hFF02;
    localparam logic [15:0] A_CHI  = 16'hFF03;
    localparam logic [15:0] A_STAT = 16'hFF04;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        is_halt;
    logic [15:0] ret_val;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rdy;
        logic [15:0] e_rdata;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_halt;
        logic [15:0] e_ret;
    } vec_t;

    vec_t vt[$];

    halt_ctrl #(
        .BASE_ADDR   (16'hFF00),
        .CYCLE_LIMIT (32'(LIMIT)),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .is_halt   (is_halt),
        .ret_val   (ret_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic rdy);
        mem_we    = we;
        mem_re    = re;
        mem_addr  = addr;
        mem_wdata = wdata;
        con_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic vec_t v(input logic we, input logic re, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic rdy,
                               input logic [15:0] e_rdata, input logic e_valid,
                               input logic [7:0] e_data, input logic e_halt,
                               input logic [15:0] e_ret);
        vec_t r;
        r.we = we; r.re = re; r.addr = addr; r.wdata = wdata; r.rdy = rdy;
        r.e_rdata = e_rdata; r.e_valid = e_valid; r.e_data = e_data;
        r.e_halt = e_halt; r.e_ret = e_ret;
        return r;
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata, vt[i].rdy);
            tick();
            chk($sformatf("%s[%0d] rdata", tag, i), 32'(mem_rdata), 32'(vt[i].e_rdata));
            chk($sformatf("%s[%0d] con_valid", tag, i), 32'(con_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid)
                chk($sformatf("%s[%0d] con_data", tag, i), 32'(con_data), 32'(vt[i].e_data));
            chk($sformatf("%s[%0d] is_halt", tag, i), 32'(is_halt), 32'(vt[i].e_halt));
            chk($sformatf("%s[%0d] ret_val", tag, i), 32'(ret_val), 32'(vt[i].e_ret));
        end
        vt.delete();
    endtask

    initial begin
        int halt_at;

        // Reset state
        do_reset();
        chk("rst rdata", 32'(mem_rdata), 32'h0);
        chk("rst con_valid", 32'(con_valid), 32'h0);
        chk("rst con_data", 32'(con_data), 32'h0);
        chk("rst is_halt", 32'(is_halt), 32'h0);
        chk("rst ret_val", 32'(ret_val), 32'h0);

        // "Hi" streamed straight through, then read decode/hold/out-of-window
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0048, 1'b1, 16'h0000, 1'b1, 8'h48, 1'b0, 16'h0));
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0069, 1'b1, 16'h0000, 1'b1, 8'h69, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, 16'hFF08, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, 16'hFF07, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, 16'hFEFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0));
        run_table("hi");

        // Overflow with sink stalled, then push+pop while full
        do_reset();
        for (int b = 0; b < 5; b++)
            vt.push_back(v(1'b1, 1'b0, A_CON, 16'(16'h41 + b), 1'b0, 16'h0000, 1'b1, 8'h41, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b0, 16'h0009, 1'b1, 8'h41, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 8'h42, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 8'h43, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 8'h44, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h000A, 1'b0, 8'h00, 1'b0, 16'h0));
        for (int b = 0; b < 4; b++)
            vt.push_back(v(1'b1, 1'b0, A_CON, 16'(16'h50 + b), 1'b0, 16'h000A, 1'b1, 8'h50, 1'b0, 16'h0));
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0054, 1'b1, 16'h000A, 1'b1, 8'h51, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b0, 16'h0009, 1'b1, 8'h51, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 8'h52, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 8'h53, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 8'h54, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b0, 8'h00, 1'b0, 16'h0));
        run_table("ovf");

        // EXIT with bytes queued: drain first, console/exit writes ignored afterwards
        do_reset();
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0061, 1'b0, 16'h0000, 1'b1, 8'h61, 1'b0, 16'h0));
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0062, 1'b0, 16'h0000, 1'b1, 8'h61, 1'b0, 16'h0));
        vt.push_back(v(1'b1, 1'b0, A_EXIT,   16'h002A, 1'b0, 16'h0000, 1'b1, 8'h61, 1'b0, 16'h0));
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0063, 1'b0, 16'h0000, 1'b1, 8'h61, 1'b0, 16'h0));
        vt.push_back(v(1'b1, 1'b0, A_EXIT,   16'h0077, 1'b0, 16'h0000, 1'b1, 8'h61, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b0, 16'h0004, 1'b1, 8'h61, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b1, 8'h62, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b0, 8'h00, 1'b0, 16'h0));
        vt.push_back(v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b0, 8'h00, 1'b1, 16'h002A));
        vt.push_back(v(1'b1, 1'b0, A_CON,    16'h0070, 1'b1, 16'h0004, 1'b0, 8'h00, 1'b1, 16'h002A));
        vt.push_back(v(1'b0, 1'b1, A_STAT,   16'h0000, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b1, 16'h002A));
        vt.push_back(v(1'b1, 1'b0, A_EXIT,   16'h0099, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b1, 16'h002A));
        run_table("exit");

        // Watchdog: DRAIN entered on edge LIMIT, HALTED on edge LIMIT+1
        do_reset();
        halt_at = 0;
        for (int k = 1; k <= 2 * int'(LIMIT); k++) begin
            tick();
            if (is_halt) begin
                halt_at = k;
                break;
            end
        end
        chk("wdog halt edge", 32'(halt_at), 32'(LIMIT + 1));
        chk("wdog ret_val", 32'(ret_val), 32'hFFFF);
        drive(1'b0, 1'b1, A_CLO, 16'h0000, 1'b0);
        tick();
        chk("wdog cycle_lo", 32'(mem_rdata), 32'(LIMIT + 1));
        drive(1'b0, 1'b1, A_CHI, 16'h0000, 1'b0);
        tick();
        chk("wdog cycle_hi", 32'(mem_rdata), 32'h0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (5) tick();
        drive(1'b0, 1'b1, A_CLO, 16'h0000, 1'b0);
        tick();
        chk("wdog cycle frozen", 32'(mem_rdata), 32'(LIMIT + 1));
        drive(1'b1, 1'b0, A_EXIT, 16'h7777, 1'b0);
        tick();
        chk("wdog halted exit ignored", 32'(ret_val), 32'hFFFF);

        // EXIT on the same edge the watchdog fires: written value wins
        do_reset();
        repeat (LIMIT - 1) tick();
        drive(1'b1, 1'b0, A_EXIT, 16'h1234, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("tie not yet halted", 32'(is_halt), 32'h0);
        tick();
        chk("tie is_halt", 32'(is_halt), 32'h1);
        chk("tie ret_val", 32'(ret_val), 32'h1234);

        // Reset pulse mid-drain, mid-handshake: queue and overflow discarded
        do_reset();
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, 1'b0, A_CON, 16'(16'h30 + b), 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, A_EXIT, 16'h0055, 1'b0);
        tick();
        drive(1'b0, 1'b1, A_STAT, 16'h0000, 1'b0);
        tick();
        chk("drain status", 32'(mem_rdata), 32'h000D);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst rdata", 32'(mem_rdata), 32'h0);
        chk("midrst con_valid", 32'(con_valid), 32'h0);
        chk("midrst con_data", 32'(con_data), 32'h0);
        chk("midrst is_halt", 32'(is_halt), 32'h0);
        chk("midrst ret_val", 32'(ret_val), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("postrst con_valid", 32'(con_valid), 32'h0);
        chk("postrst is_halt", 32'(is_halt), 32'h0);
        drive(1'b0, 1'b1, A_STAT, 16'h0000, 1'b1);
        tick();
        chk("postrst status", 32'(mem_rdata), 32'h0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00, meaning the MMIO window base (8 word offsets).
REQ-002 SHALL have parameter CYCLE_LIMIT, default 32'd500000, meaning the watchdog halt threshold in cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning console FIFO entries (power of 2).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_we  input  1  CPU store strobe, one cycle per store.
REQ-007 mem_re  input  1  CPU load strobe, one cycle per load.
REQ-008 mem_addr  input  16  word address; decoded only when in [BASE_ADDR, BASE_ADDR+7].
REQ-009 mem_wdata  input  16  store data.
REQ-010 mem_rdata  output  16  load data, registered.
REQ-011 con_valid  output  1  console byte available.
REQ-012 con_data  output  8  console byte.
REQ-013 con_ready  input  1  console sink accepts byte when high with con_valid.
REQ-014 is_halt  output  1  program finished; level, sticky until reset.
REQ-015 ret_val  output  16  program exit value, valid while is_halt=1.

Function
REQ-016 Offset map: 0 CONSOLE (W, byte=wdata[7:0]); 1 EXIT (W); 2 CYCLE_LO (R); 3 CYCLE_HI (R); 4 STATUS (R); 5-7 read 0, writes ignored.
REQ-017 STATUS SHALL be {12'b0, overflow, state==DRAIN, fifo_empty, fifo_full} with fifo_full at bit 0.
REQ-018 mem_rdata SHALL update on the cycle after mem_re=1 and hold otherwise; out-of-window or unmapped reads return 16'h0000.
REQ-019 Reading CYCLE_LO SHALL capture cycle[31:16] into a shadow register; CYCLE_HI reads return the shadow.
REQ-020 FSM states RUN, DRAIN, HALTED.
REQ-021 RUN -> DRAIN on EXIT write; ret register captures mem_wdata in the same edge.
REQ-022 RUN -> DRAIN when cycle count equals CYCLE_LIMIT-1 and no EXIT write; ret register := 16'hFFFF.
REQ-023 Simultaneous EXIT write and watchdog: EXIT wins, ret = mem_wdata.
REQ-024 DRAIN -> HALTED on the first cycle the FIFO is empty; is_halt=1 and ret_val=ret register from the cycle HALTED is entered.
REQ-025 HALTED SHALL be terminal until rst_n=0; all writes ignored; reads still served.
REQ-026 CONSOLE write in RUN with FIFO not full SHALL push; with FIFO full SHALL drop the byte and set sticky overflow.
REQ-027 CONSOLE and EXIT writes in DRAIN SHALL be ignored.
REQ-028 Push and pop in the same cycle SHALL both take effect and keep occupancy unchanged, including when full.
REQ-029 con_valid = FIFO not empty; pop when con_valid & con_ready; con_data = head entry, stable while con_valid & !con_ready.
REQ-030 32-bit cycle counter SHALL increment every cycle in RUN and DRAIN, freeze in HALTED, and saturate at 32'hFFFFFFFF.
REQ-031 ret_val SHALL read 16'h0000 while is_halt=0.

Reset
REQ-032 rst_n=0 SHALL immediately force: state RUN, FIFO empty, overflow 0, cycle 0, shadow 0, ret 0, mem_rdata 0, is_halt 0, ret_val 0, con_valid 0, con_data 0.
REQ-033 Reset asserted mid-DRAIN or mid-handshake SHALL discard queued bytes without popping them.

Structure
REQ-034 Package halt_ctrl_pkg SHALL hold the state enum, register offset constants, and WATCHDOG_RET=16'hFFFF.
REQ-035 FIFO SHALL be a separate sub-module halt_fifo (sync, parameterised depth/width, full/empty flags, async active-low reset).

Verification
REQ-036 Write 'H','i' to BASE+0, con_ready=1 -> con_data 8'h48 then 8'h69, one per cycle, FIFO empty after.
REQ-037 con_ready=0, write 5 bytes -> first 4 queued, STATUS=16'h0009 (overflow, full); release ready -> exactly 4 bytes out.
REQ-038 2 bytes queued, con_ready=0, write 16'h002A to BASE+1 -> STATUS bit 2 set, is_halt=0; raise con_ready -> 2 bytes out, then is_halt=1, ret_val=16'h002A.
REQ-039 CYCLE_LIMIT=100, no EXIT -> is_halt=1 at cycle 100 with ret_val=16'hFFFF; cycle count frozen afterwards.
REQ-040 EXIT write in the watchdog cycle -> ret_val = written value; rst_n pulse in DRAIN -> all outputs 0, state RUN.
